// File: rtl/uart_loader_pkg.sv
// rtl/uart_loader_pkg.sv - shared types and defaults for the UART boot loader
package uart_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } parse_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam int         CLK_DIV_DEFAULT  = 16;
    localparam logic [7:0] CMD_WR_DEFAULT   = 8'h02;
    localparam logic [7:0] CMD_BOOT_DEFAULT = 8'h03;

    // Word-aligned increment; wraps FFFF_FFFC -> 0 by plain 32-bit overflow.
    function automatic logic [31:0] next_word_addr(input logic [31:0] a);
        return a + 32'd4;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 receiver: synchronizer, mid-bit sampling, stop-bit check
module uart_rx_byte
    import uart_loader_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err
);

    localparam int             CW        = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0]  BIT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(CLK_DIV / 2 - 1);

    rx_state_t     state;
    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RX_IDLE;
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        state    <= RX_START;
                        baud_cnt <= '0;
                    end
                end
                RX_START: begin
                    // A start bit that is high again at mid-bit was only a glitch.
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        shreg    <= {rx_sync, shreg[7:1]};
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= RX_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        state    <= RX_IDLE;
                        if (rx_sync) begin
                            data       <= shreg;
                            data_valid <= 1'b1;
                        end else begin
                            frame_err  <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_mem_loader.sv
// rtl/uart_mem_loader.sv - UART boot-load frame parser with one-entry req/gnt write port
module uart_mem_loader
    import uart_loader_pkg::*;
#(
    parameter int         CLK_DIV  = CLK_DIV_DEFAULT,
    parameter logic [7:0] CMD_WR   = CMD_WR_DEFAULT,
    parameter logic [7:0] CMD_BOOT = CMD_BOOT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx_i,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic        fetch_en_o,
    output logic        busy_o,
    output logic        frame_err_o,
    output logic        overrun_o,
    output logic        bad_cmd_o
);

    logic [7:0]   rx_byte;
    logic         rx_valid;
    logic         rx_ferr;

    parse_state_t state;
    logic [1:0]   cnt;
    logic [31:0]  addr;
    logic [31:0]  word;
    logic [31:0]  addr_next;
    logic         post_valid;
    logic [31:0]  post_addr;
    logic [31:0]  post_data;

    uart_rx_byte #(
        .CLK_DIV (CLK_DIV)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (uart_rx_i),
        .data       (rx_byte),
        .data_valid (rx_valid),
        .frame_err  (rx_ferr)
    );

    assign addr_next = next_word_addr(addr);
    assign mem_we_o  = 1'b1;
    assign mem_be_o  = 4'hF;
    // post_valid covers the one cycle between parser returning to IDLE and req rising.
    assign busy_o    = (state != IDLE) || post_valid || mem_req_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            addr       <= '0;
            word       <= '0;
            post_valid <= 1'b0;
            post_addr  <= '0;
            post_data  <= '0;
            fetch_en_o <= 1'b0;
            bad_cmd_o  <= 1'b0;
        end else begin
            post_valid <= 1'b0;
            if (rx_valid) begin
                case (state)
                    IDLE: begin
                        if (rx_byte == CMD_WR) begin
                            state <= ADDR;
                            cnt   <= '0;
                            addr  <= '0;
                        end else if (rx_byte == CMD_BOOT) begin
                            fetch_en_o <= 1'b1;
                        end else begin
                            bad_cmd_o  <= 1'b1;
                        end
                    end
                    ADDR: begin
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            addr  <= {addr[23:0], rx_byte[7:2], 2'b00};
                            state <= DATA;
                            cnt   <= '0;
                        end else begin
                            addr  <= {addr[23:0], rx_byte};
                        end
                    end
                    DATA: begin
                        cnt  <= cnt + 2'd1;
                        word <= {word[23:0], rx_byte};
                        if (cnt == 2'd3) begin
                            post_valid <= 1'b1;
                            post_addr  <= addr;
                            post_data  <= {word[23:0], rx_byte};
                            addr       <= addr_next;
                            cnt        <= '0;
                            // Frames end at each 16-byte boundary; host resends a header.
                            if (addr_next[3:0] == 4'h0) state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req_o   <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            overrun_o   <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            if (rx_ferr) frame_err_o <= 1'b1;
            if (post_valid) begin
                // A grant in this same cycle frees the slot, so the new word may load.
                if (mem_req_o && !mem_gnt_i) begin
                    overrun_o <= 1'b1;
                end else begin
                    mem_req_o   <= 1'b1;
                    mem_addr_o  <= post_addr;
                    mem_wdata_o <= post_data;
                end
            end else if (mem_req_o && mem_gnt_i) begin
                mem_req_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_mem_loader.sv
// tb/tb_uart_mem_loader.sv - directed self-checking bench for uart_mem_loader
module tb_uart_mem_loader;

    logic        clk;
    logic        rst_n;
    logic        rx_a    [3];
    logic        gnt_a   [3];
    logic        req_a   [3];
    logic [31:0] addr_a  [3];
    logic [31:0] wdata_a [3];
    logic        we_a    [3];
    logic [3:0]  be_a    [3];
    logic        fetch_a [3];
    logic        busy_a  [3];
    logic        ferr_a  [3];
    logic        ovr_a   [3];
    logic        bad_a   [3];

    int          tests_run;
    int          tests_failed;
    logic [65:0] wlog [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_mem_loader #(.CLK_DIV(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .uart_rx_i(rx_a[0]),
        .mem_req_o(req_a[0]), .mem_gnt_i(gnt_a[0]), .mem_addr_o(addr_a[0]),
        .mem_wdata_o(wdata_a[0]), .mem_we_o(we_a[0]), .mem_be_o(be_a[0]),
        .fetch_en_o(fetch_a[0]), .busy_o(busy_a[0]), .frame_err_o(ferr_a[0]),
        .overrun_o(ovr_a[0]), .bad_cmd_o(bad_a[0])
    );

    uart_mem_loader #(.CLK_DIV(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .uart_rx_i(rx_a[1]),
        .mem_req_o(req_a[1]), .mem_gnt_i(gnt_a[1]), .mem_addr_o(addr_a[1]),
        .mem_wdata_o(wdata_a[1]), .mem_we_o(we_a[1]), .mem_be_o(be_a[1]),
        .fetch_en_o(fetch_a[1]), .busy_o(busy_a[1]), .frame_err_o(ferr_a[1]),
        .overrun_o(ovr_a[1]), .bad_cmd_o(bad_a[1])
    );

    uart_mem_loader #(.CLK_DIV(27)) u_dut27 (
        .clk(clk), .rst_n(rst_n), .uart_rx_i(rx_a[2]),
        .mem_req_o(req_a[2]), .mem_gnt_i(gnt_a[2]), .mem_addr_o(addr_a[2]),
        .mem_wdata_o(wdata_a[2]), .mem_we_o(we_a[2]), .mem_be_o(be_a[2]),
        .fetch_en_o(fetch_a[2]), .busy_o(busy_a[2]), .frame_err_o(ferr_a[2]),
        .overrun_o(ovr_a[2]), .bad_cmd_o(bad_a[2])
    );

    // Every granted transfer, tagged with the instance that issued it.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++)
            if (req_a[i] === 1'b1 && gnt_a[i] === 1'b1)
                wlog.push_back({2'(i), addr_a[i], wdata_a[i]});
    end

    function automatic int div_of(input int s);
        case (s)
            0:       return 16;
            1:       return 8;
            default: return 27;
        endcase
    endfunction

    function automatic logic [74:0] out_vec(input int s);
        return {req_a[s], addr_a[s], wdata_a[s], we_a[s], be_a[s],
                fetch_a[s], busy_a[s], ferr_a[s], ovr_a[s], bad_a[s]};
    endfunction

    task automatic send_byte(input int s, input logic [7:0] b, input logic stop);
        int d;
        d = div_of(s);
        rx_a[s] = 1'b0;
        repeat (d) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_a[s] = b[i];
            repeat (d) @(negedge clk);
        end
        rx_a[s] = stop;
        repeat (d) @(negedge clk);
        rx_a[s] = 1'b1;
        if (!stop) repeat (2 * d) @(negedge clk);
    endtask

    task automatic send_word(input int s, input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(s, w[i*8 +: 8], 1'b1);
    endtask

    task automatic send_header(input int s, input logic [31:0] a);
        send_byte(s, 8'h02, 1'b1);
        send_word(s, a);
    endtask

    task automatic test_reset();
        logic [74:0] exp_v;
        exp_v = {1'b0, 32'h0, 32'h0, 1'b1, 4'hF, 5'b0};
        for (int s = 0; s < 3; s++) begin
            tests_run++;
            if (out_vec(s) !== exp_v) begin
                tests_failed++;
                $display("FAIL reset_state[%0d]: got %h expected %h", s, out_vec(s), exp_v);
            end
        end
    endtask

    task automatic test_four_words();
        logic [65:0] exp_q [$];
        logic [65:0] got;
        wlog.delete();
        send_header(0, 32'h0000_0000);
        send_word(0, 32'hDEADBEEF);
        send_word(0, 32'h01234567);
        send_word(0, 32'h89ABCDEF);
        send_word(0, 32'h0BADF00D);
        repeat (64) @(negedge clk);
        exp_q = '{{2'd0, 32'h0, 32'hDEADBEEF}, {2'd0, 32'h4, 32'h01234567},
                  {2'd0, 32'h8, 32'h89ABCDEF}, {2'd0, 32'hC, 32'h0BADF00D}};
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (wlog.size() == 0) begin
                tests_failed++;
                $display("FAIL four_words write %0d: got none expected %h", k, exp_q[k]);
            end else begin
                got = wlog.pop_front();
                if (got !== exp_q[k]) begin
                    tests_failed++;
                    $display("FAIL four_words write %0d: got %h expected %h", k, got, exp_q[k]);
                end
            end
        end
        tests_run++;
        if (wlog.size() != 0 || busy_a[0] !== 1'b0 || ovr_a[0] !== 1'b0 || ferr_a[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL four_words idle: got extra=%0d busy=%b ovr=%b ferr=%b expected 0 0 0 0",
                     wlog.size(), busy_a[0], ovr_a[0], ferr_a[0]);
        end
    endtask

    task automatic test_boot_frame();
        logic [65:0] exp_q [$];
        logic [65:0] got;
        wlog.delete();
        send_header(0, 32'h0010_0008);
        send_word(0, 32'hCAFEBABE);
        send_word(0, 32'h5A5AA5A5);
        repeat (64) @(negedge clk);
        exp_q = '{{2'd0, 32'h0010_0008, 32'hCAFEBABE}, {2'd0, 32'h0010_000C, 32'h5A5AA5A5}};
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            got = (wlog.size() != 0) ? wlog.pop_front() : 66'h0;
            if (got !== exp_q[k]) begin
                tests_failed++;
                $display("FAIL boot_frame write %0d: got %h expected %h", k, got, exp_q[k]);
            end
        end
        tests_run++;
        if (busy_a[0] !== 1'b0 || fetch_a[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL boot_frame pre_boot: got busy=%b fetch=%b expected 0 0", busy_a[0], fetch_a[0]);
        end
        send_byte(0, 8'h03, 1'b1);
        repeat (8) @(negedge clk);
        tests_run++;
        if (fetch_a[0] !== 1'b1 || bad_a[0] !== 1'b0 || wlog.size() != 0) begin
            tests_failed++;
            $display("FAIL boot_cmd: got fetch=%b bad=%b writes=%0d expected 1 0 0",
                     fetch_a[0], bad_a[0], wlog.size());
        end
    endtask

    task automatic test_frame_err();
        logic [65:0] exp_q [$];
        logic [65:0] got;
        wlog.delete();
        send_byte(0, 8'h02, 1'b1);
        send_byte(0, 8'h00, 1'b1);
        send_byte(0, 8'h10, 1'b1);
        send_byte(0, 8'hAA, 1'b0);
        tests_run++;
        if (ferr_a[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL frame_err flag: got %b expected 1", ferr_a[0]);
        end
        send_byte(0, 8'h00, 1'b1);
        send_byte(0, 8'h08, 1'b1);
        send_word(0, 32'h11111111);
        send_word(0, 32'h22222222);
        repeat (64) @(negedge clk);
        exp_q = '{{2'd0, 32'h0010_0008, 32'h11111111}, {2'd0, 32'h0010_000C, 32'h22222222}};
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            got = (wlog.size() != 0) ? wlog.pop_front() : 66'h0;
            if (got !== exp_q[k]) begin
                tests_failed++;
                $display("FAIL frame_err write %0d: got %h expected %h", k, got, exp_q[k]);
            end
        end
    endtask

    task automatic test_bad_cmd_glitch();
        wlog.delete();
        rx_a[0] = 1'b0;
        repeat (5) @(negedge clk);
        rx_a[0] = 1'b1;
        repeat (48) @(negedge clk);
        tests_run++;
        if (bad_a[0] !== 1'b0 || busy_a[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch: got bad=%b busy=%b expected 0 0", bad_a[0], busy_a[0]);
        end
        send_byte(0, 8'h55, 1'b1);
        repeat (48) @(negedge clk);
        tests_run++;
        if (bad_a[0] !== 1'b1 || busy_a[0] !== 1'b0 || wlog.size() != 0 || req_a[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL bad_cmd: got bad=%b busy=%b writes=%0d req=%b expected 1 0 0 0",
                     bad_a[0], busy_a[0], wlog.size(), req_a[0]);
        end
    endtask

    task automatic test_overrun();
        logic [65:0] got;
        logic [65:0] exp_w;
        wlog.delete();
        gnt_a[0] = 1'b0;
        send_header(0, 32'h0000_0100);
        send_word(0, 32'hA1A1A1A1);
        repeat (8) @(negedge clk);
        tests_run++;
        if (req_a[0] !== 1'b1 || ovr_a[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL overrun first_req: got req=%b ovr=%b expected 1 0", req_a[0], ovr_a[0]);
        end
        send_word(0, 32'hB2B2B2B2);
        send_word(0, 32'hC3C3C3C3);
        send_word(0, 32'hD4D4D4D4);
        repeat (160) @(negedge clk);
        tests_run++;
        if ({req_a[0], addr_a[0], wdata_a[0], ovr_a[0]} !== {1'b1, 32'h100, 32'hA1A1A1A1, 1'b1}) begin
            tests_failed++;
            $display("FAIL overrun held: got req=%b addr=%h data=%h ovr=%b expected 1 00000100 a1a1a1a1 1",
                     req_a[0], addr_a[0], wdata_a[0], ovr_a[0]);
        end
        tests_run++;
        if (wlog.size() != 0) begin
            tests_failed++;
            $display("FAIL overrun no_grant: got %0d writes expected 0", wlog.size());
        end
        gnt_a[0] = 1'b1;
        repeat (50) @(negedge clk);
        exp_w = {2'd0, 32'h100, 32'hA1A1A1A1};
        tests_run++;
        got = (wlog.size() != 0) ? wlog.pop_front() : 66'h0;
        if (got !== exp_w) begin
            tests_failed++;
            $display("FAIL overrun granted write: got %h expected %h", got, exp_w);
        end
        tests_run++;
        if (wlog.size() != 0 || req_a[0] !== 1'b0 || busy_a[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL overrun after_gnt: got extra=%0d req=%b busy=%b expected 0 0 0",
                     wlog.size(), req_a[0], busy_a[0]);
        end
    endtask

    task automatic test_mid_frame_reset(input int s);
        logic [74:0] exp_v;
        logic [65:0] exp_q [$];
        logic [65:0] got;
        exp_v = {1'b0, 32'h0, 32'h0, 1'b1, 4'hF, 5'b0};
        gnt_a[s] = 1'b1;
        wlog.delete();
        send_header(s, 32'h0000_0000);
        send_byte(s, 8'hAA, 1'b1);
        send_byte(s, 8'hBB, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (out_vec(s) !== exp_v) begin
            tests_failed++;
            $display("FAIL mid_reset[%0d] state: got %h expected %h", s, out_vec(s), exp_v);
        end
        send_header(s, 32'h0000_0028);
        send_word(s, 32'h11223344);
        send_word(s, 32'h55667788);
        repeat (4 * div_of(s)) @(negedge clk);
        exp_q = '{{2'(s), 32'h28, 32'h11223344}, {2'(s), 32'h2C, 32'h55667788}};
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            got = (wlog.size() != 0) ? wlog.pop_front() : 66'h0;
            if (got !== exp_q[k]) begin
                tests_failed++;
                $display("FAIL mid_reset[%0d] write %0d: got %h expected %h", s, k, got, exp_q[k]);
            end
        end
        tests_run++;
        if (wlog.size() != 0 || busy_a[s] !== 1'b0 || ovr_a[s] !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset[%0d] idle: got extra=%0d busy=%b ovr=%b expected 0 0 0",
                     s, wlog.size(), busy_a[s], ovr_a[s]);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rx_a[i]  = 1'b1;
            gnt_a[i] = 1'b1;
        end
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        test_reset();
        test_four_words();
        test_boot_frame();
        test_frame_err();
        test_bad_cmd_glitch();
        test_overrun();
        for (int s = 0; s < 3; s++) test_mid_frame_reset(s);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
